// File: rtl/line_arbiter_pkg.sv
// Shared LC-3b memory-side types for the line arbiter and its optional ifetch line buffer.
package lc3b_types;

    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_wb_adr;
    typedef logic [15:0]  lc3b_mem_sel;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE
    } lc3b_arb_state;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } lc3b_arb_port;

endpackage

// File: rtl/line_arbiter_ibuf.sv
// One-entry ifetch line buffer: a single tagged copy of the most recently fetched instruction line.
module ifetch_line_buffer
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  lc3b_wb_adr lookup_addr,
    output logic       hit,
    output lc3b_line   line,
    input  logic       fill_en,
    input  lc3b_wb_adr fill_tag,
    input  lc3b_line   fill_line,
    input  logic       inv_en,
    input  lc3b_wb_adr inv_addr
);

    logic       valid;
    lc3b_wb_adr tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (fill_en) begin
            valid <= 1'b1;
        end else if (inv_en && valid && (inv_addr == tag)) begin
            valid <= 1'b0;
        end
    end

    // NOTE: tag and line are storage guarded by valid, so they are left out of reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag  <= fill_tag;
            line <= fill_line;
        end
    end

    assign hit = valid && (tag == lookup_addr);

endmodule

// File: rtl/line_arbiter.sv
// Round-robin arbiter sharing one physical memory port between ifetch and data line requests.
// Define LINE_ARBITER_IBUF_EN to add a one-entry ifetch line buffer in front of pmem.
module line_arbiter
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifetch_read,
    input  lc3b_wb_adr  ifetch_address,
    output lc3b_line    ifetch_rdata,
    output logic        ifetch_resp,
    input  logic        mem_read,
    input  logic        mem_write,
    input  lc3b_wb_adr  mem_address,
    input  lc3b_line    mem_wdata,
    input  lc3b_mem_sel mem_sel,
    output lc3b_line    mem_rdata,
    output logic        mem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output lc3b_wb_adr  pmem_address,
    output lc3b_line    pmem_wdata,
    output lc3b_mem_sel pmem_sel,
    input  lc3b_line    pmem_rdata,
    input  logic        pmem_resp
);

    lc3b_arb_state state;
    lc3b_arb_port  last_served;
    lc3b_wb_adr    lat_addr;
    lc3b_line      lat_wdata;
    lc3b_mem_sel   lat_sel;

    logic     data_req;
    logic     grant_d;
    logic     grant_i;
    logic     ibuf_hit;
    lc3b_line ibuf_line;

    assign data_req = mem_read | mem_write;
    assign grant_d  = data_req && (!ifetch_read || last_served == PORT_I);
    assign grant_i  = ifetch_read && !grant_d;

`ifdef LINE_ARBITER_IBUF_EN
    logic ibuf_fill;
    logic ibuf_inv;

    assign ibuf_fill = (state == SERVE_I) && pmem_resp;
    assign ibuf_inv  = (state == IDLE) && grant_d && mem_write;

    ifetch_line_buffer u_ibuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_addr(ifetch_address),
        .hit        (ibuf_hit),
        .line       (ibuf_line),
        .fill_en    (ibuf_fill),
        .fill_tag   (lat_addr),
        .fill_line  (pmem_rdata),
        .inv_en     (ibuf_inv),
        .inv_addr   (mem_address)
    );
`else
    assign ibuf_hit  = 1'b0;
    assign ibuf_line = '0;
`endif

    // pmem_* come only from the latched copy, so requesters may change inputs freely mid-transaction.
    assign pmem_address = lat_addr;
    assign pmem_wdata   = lat_wdata;
    assign pmem_sel     = lat_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_served  <= PORT_I;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_sel      <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            ifetch_resp  <= 1'b0;
            mem_resp     <= 1'b0;
            ifetch_rdata <= '0;
            mem_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ifetch_read && ibuf_hit && !data_req) begin
                        state        <= DONE;
                        last_served  <= PORT_I;
                        ifetch_resp  <= 1'b1;
                        ifetch_rdata <= ibuf_line;
                    end else if (grant_d) begin
                        state       <= SERVE_D;
                        last_served <= PORT_D;
                        lat_addr    <= mem_address;
                        lat_wdata   <= mem_wdata;
                        lat_sel     <= mem_sel;
                        // Read and write together resolve to a write.
                        pmem_write  <= mem_write;
                        pmem_read   <= !mem_write;
                    end else if (grant_i) begin
                        state       <= SERVE_I;
                        last_served <= PORT_I;
                        lat_addr    <= ifetch_address;
                        lat_wdata   <= '0;
                        lat_sel     <= '0;
                        pmem_read   <= 1'b1;
                        pmem_write  <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state      <= DONE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        if (state == SERVE_I) begin
                            ifetch_resp  <= 1'b1;
                            ifetch_rdata <= pmem_rdata;
                        end else begin
                            mem_resp  <= 1'b1;
                            mem_rdata <= pmem_rdata;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    ifetch_resp <= 1'b0;
                    mem_resp    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_arbiter.sv
// Self-checking bench for line_arbiter: table of single transactions plus hand-written corner sequences.
// The buffer sequence runs only when LINE_ARBITER_IBUF_EN is defined.
module tb_line_arbiter;
    import lc3b_types::*;

    logic        clk;
    logic        rst_n;
    logic        ifetch_read;
    lc3b_wb_adr  ifetch_address;
    lc3b_line    ifetch_rdata;
    logic        ifetch_resp;
    logic        mem_read;
    logic        mem_write;
    lc3b_wb_adr  mem_address;
    lc3b_line    mem_wdata;
    lc3b_mem_sel mem_sel;
    lc3b_line    mem_rdata;
    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    lc3b_wb_adr  pmem_address;
    lc3b_line    pmem_wdata;
    lc3b_mem_sel pmem_sel;
    lc3b_line    pmem_rdata;
    logic        pmem_resp;

    int n_tests;
    int n_fail;
    int overlap;

    line_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifetch_read   (ifetch_read),
        .ifetch_address(ifetch_address),
        .ifetch_rdata  (ifetch_rdata),
        .ifetch_resp   (ifetch_resp),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_sel       (mem_sel),
        .mem_rdata     (mem_rdata),
        .mem_resp      (mem_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_sel      (pmem_sel),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (pmem_read && pmem_write) overlap++;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        ird;
        lc3b_wb_adr  iadr;
        logic        mrd;
        logic        mwr;
        lc3b_wb_adr  madr;
        lc3b_mem_sel sel;
        lc3b_line    wdata;
        lc3b_line    rdata;
        int          lat;
        logic        exp_d;
    } vec_t;

    function automatic vec_t mk(input logic ird, input lc3b_wb_adr iadr, input logic mrd,
                                input logic mwr, input lc3b_wb_adr madr, input lc3b_mem_sel sel,
                                input lc3b_line wdata, input lc3b_line rdata, input int lat,
                                input logic exp_d);
        vec_t v;
        v.ird = ird; v.iadr = iadr; v.mrd = mrd; v.mwr = mwr; v.madr = madr;
        v.sel = sel; v.wdata = wdata; v.rdata = rdata; v.lat = lat; v.exp_d = exp_d;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ifetch_read = 1'b0; ifetch_address = '0;
        mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0; mem_sel = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Presents one request at cycle 0, scrambles inputs from cycle 1, answers after v.lat cycles.
    task automatic run_txn(input vec_t v);
        lc3b_wb_adr  e_addr;
        lc3b_mem_sel e_sel;
        logic        e_wr;
        e_addr = v.exp_d ? v.madr : v.iadr;
        e_sel  = v.exp_d ? v.sel : 16'h0000;
        e_wr   = v.exp_d && v.mwr;
        ifetch_read = v.ird; ifetch_address = v.iadr;
        mem_read = v.mrd; mem_write = v.mwr; mem_address = v.madr;
        mem_sel = v.sel; mem_wdata = v.wdata;
        @(negedge clk);
        ifetch_read = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        ifetch_address = 12'hDEF; mem_address = 12'hABC; mem_sel = 16'h1234; mem_wdata = '1;
        for (int c = 1; c <= v.lat; c++) begin
            if (c > 1) @(negedge clk);
            check("pmem_read", pmem_read, !e_wr);
            check("pmem_write", pmem_write, e_wr);
            check("pmem_address", pmem_address, e_addr);
            check("pmem_sel", pmem_sel, e_sel);
            if (e_wr) check("pmem_wdata", pmem_wdata, v.wdata);
            check("resp_early", ifetch_resp | mem_resp, 1'b0);
            if (c == v.lat) begin
                pmem_resp = 1'b1;
                pmem_rdata = v.rdata;
            end
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        pmem_rdata = ~v.rdata;
        check("ifetch_resp", ifetch_resp, !v.exp_d);
        check("mem_resp", mem_resp, v.exp_d);
        check("rdata", v.exp_d ? mem_rdata : ifetch_rdata, v.rdata);
        check("pmem_idle_done", pmem_read | pmem_write, 1'b0);
        @(negedge clk);
        check("resp_one_cycle", ifetch_resp | mem_resp, 1'b0);
        check("rdata_hold", v.exp_d ? mem_rdata : ifetch_rdata, v.rdata);
    endtask

    vec_t vecs[7];

    initial begin
        lc3b_wb_adr rr_exp[4];
        int         seen;
        n_tests = 0;
        n_fail  = 0;
        overlap = 0;

        vecs[0] = mk(1, 12'h020, 0, 1, 12'h030, 16'h00FF, {4{32'h1111_2222}}, {8{16'h0BAD}}, 2, 1);
        vecs[1] = mk(1, 12'h020, 1, 0, 12'h031, 16'hFFFF, '0, {4{32'hCAFE_F00D}}, 3, 0);
        vecs[2] = mk(0, 12'h000, 1, 1, 12'h055, 16'hFFFF, {2{64'h0123_4567_89AB_CDEF}}, {16{8'h3C}}, 1, 1);
        vecs[3] = mk(1, 12'h010, 0, 0, 12'h000, 16'h0000, '0, {16{8'hA5}}, 4, 0);
        vecs[4] = mk(0, 12'h000, 1, 0, 12'h7FF, 16'hF0F0, '0, {4{32'hDEAD_BEEF}}, 2, 1);
        vecs[5] = mk(1, 12'hFFF, 0, 0, 12'h000, 16'h0000, '0, {16{8'h5A}}, 1, 0);
        vecs[6] = mk(1, 12'h100, 1, 0, 12'h000, 16'h0001, '0, {16{8'h77}}, 2, 1);

        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_pmem_rw", {pmem_read, pmem_write}, 2'b00);
        check("rst_resp", {ifetch_resp, mem_resp}, 2'b00);
        check("rst_pmem_address", pmem_address, 12'h000);
        check("rst_pmem_sel", pmem_sel, 16'h0000);
        check("rst_rdata", ifetch_rdata | mem_rdata, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // Both ports held: grants must alternate starting with data.
        do_reset();
        rr_exp[0] = 12'h222; rr_exp[1] = 12'h111; rr_exp[2] = 12'h222; rr_exp[3] = 12'h111;
        ifetch_read = 1'b1; ifetch_address = 12'h111;
        mem_read = 1'b1; mem_address = 12'h222;
        for (int t = 0; t < 4; t++) begin
            int w = 0;
            while (!(pmem_read || pmem_write) && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("rr_wait_bound", w < 20, 1'b1);
            check("rr_order", pmem_address, rr_exp[t]);
            pmem_resp = 1'b1;
            pmem_rdata = {120'h0, 8'(t)};
            @(negedge clk);
            pmem_resp = 1'b0;
            if (t == 3) begin
                ifetch_read = 1'b0;
                mem_read = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        check("rr_no_extra_grant", pmem_read | pmem_write, 1'b0);

        // Reset in the middle of a data write.
        do_reset();
        mem_write = 1'b1; mem_address = 12'h3AA; mem_sel = 16'hFFFF; mem_wdata = {4{32'h5555_AAAA}};
        @(negedge clk);
        check("mid_rst_write_on", pmem_write, 1'b1);
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pmem_rw", {pmem_read, pmem_write}, 2'b00);
        check("mid_rst_pmem_address", pmem_address, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        pmem_resp = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (mem_resp || ifetch_resp) seen++;
        end
        check("mid_rst_no_resp", seen, 0);

`ifdef LINE_ARBITER_IBUF_EN
        do_reset();
        run_txn(mk(1, 12'h040, 0, 0, 12'h000, 16'h0000, '0, {8{16'hBEEF}}, 2, 0));
        ifetch_read = 1'b1; ifetch_address = 12'h040;
        @(negedge clk);
        ifetch_read = 1'b0;
        check("ibuf_hit_resp", ifetch_resp, 1'b1);
        check("ibuf_hit_rdata", ifetch_rdata, {8{16'hBEEF}});
        check("ibuf_hit_no_pmem", pmem_read, 1'b0);
        @(negedge clk);
        check("ibuf_hit_one_cycle", ifetch_resp, 1'b0);
        run_txn(mk(0, 12'h000, 0, 1, 12'h040, 16'hFFFF, {4{32'h0F0F_0F0F}}, '0, 1, 1));
        run_txn(mk(1, 12'h040, 0, 0, 12'h000, 16'h0000, '0, {8{16'h1357}}, 1, 0));
`endif

        check("rd_wr_exclusive", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
